// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// and the ALUOp / ALUSrcB / PCSrc mux selects also used by the ALU control decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_ERR    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

  // States that stall on the memory handshake and are covered by the watchdog.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the shared datapath.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             branch;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic             instr_done;
  logic [CNT_W-1:0] instr_cnt;
  logic             bus_err;
  logic             halted;
  logic [3:0]       state_o;

  modport master (
    input  opcode, mem_ready,
    output pc_write, branch, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_src, instr_done, instr_cnt, bus_err, halted, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, branch, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_src, instr_done, instr_cnt, bus_err, halted, state_o
  );

endinterface

// File: rtl/ctrl_watchdog.sv
// Memory-stall watchdog: counts consecutive not-ready cycles in a waiting state
// and flags a timeout on the MAX_WAIT-th one unless the access completes then.
module ctrl_watchdog #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  logic [7:0] wait_cnt_reg;

  assign timeout = active && !mem_ready && (wait_cnt_reg == 8'(MAX_WAIT - 1));

  // Any exit from a waiting state happens through mem_ready or timeout, so
  // clearing on those (or when idle) also covers the clear-on-state-change rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if (!active || mem_ready || timeout) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle main control FSM: sequences fetch/decode/execute for R-type, LW, SW,
// BEQ, ADDI and J, counts retired instructions and halts on stalls or bad opcodes.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input logic              clk,
  input logic              rst_n,
  multicycle_ctrl_if.master bus
);

  state_t           state_reg;
  logic [5:0]       opcode_reg;
  logic [CNT_W-1:0] instr_cnt_reg;
  logic             timeout;
  logic             retire;
  ctrl_t            ctrl;

  ctrl_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (is_mem_wait(state_reg)),
    .mem_ready (bus.mem_ready),
    .timeout   (timeout)
  );

  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
      S_MEMWR:                                      retire = bus.mem_ready;
      default:                                      retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_FETCH;
      opcode_reg    <= '0;
      instr_cnt_reg <= '0;
    end else begin
      if (retire) begin
        instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
      end
      case (state_reg)
        S_FETCH: begin
          if (bus.mem_ready)  state_reg <= S_DECODE;
          else if (timeout)   state_reg <= S_ERR;
        end
        S_DECODE: begin
          opcode_reg <= bus.opcode;
          case (bus.opcode)
            OP_RTYPE:     state_reg <= S_EXEC;
            OP_LW, OP_SW: state_reg <= S_MEMADR;
            OP_BEQ:       state_reg <= S_BRANCH;
            OP_ADDI:      state_reg <= S_ADDIEX;
            OP_J:         state_reg <= S_JUMP;
            default:      state_reg <= S_ERR;
          endcase
        end
        // Only LW and SW reach here, so anything that is not LW is a store.
        S_MEMADR: state_reg <= (opcode_reg == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (bus.mem_ready)  state_reg <= S_MEMWB;
          else if (timeout)   state_reg <= S_ERR;
        end
        S_MEMWR: begin
          if (bus.mem_ready)  state_reg <= S_FETCH;
          else if (timeout)   state_reg <= S_ERR;
        end
        S_EXEC:   state_reg <= S_ALUWB;
        S_ADDIEX: state_reg <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_reg <= S_FETCH;
        S_ERR:    state_reg <= S_ERR;
        default:  state_reg <= S_ERR;
      endcase
    end
  end

  // Moore decode; FETCH additionally gates IR/PC loads with mem_ready.
  always_comb begin
    ctrl = '0;
    case (state_reg)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      S_ERR:    ctrl.halted = 1'b1;
      default:  ctrl = '0;
    endcase
  end

  assign bus.pc_write   = ctrl.pc_write;
  assign bus.branch     = ctrl.branch;
  assign bus.iord       = ctrl.iord;
  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.halted     = ctrl.halted;
  assign bus.instr_done = retire;
  assign bus.instr_cnt  = instr_cnt_reg;
  assign bus.bus_err    = timeout;
  assign bus.state_o    = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: vector table through a scoreboard queue, then
// hand sequences for ERR hold, watchdog boundary and async reset mid-store.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(
    .MAX_WAIT (15),
    .CNT_W    (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
  } ctl_t;

  typedef struct {
    logic [5:0] opc;
    logic       rdy;
    int         st;
    logic       done;
    int         cnt;
  } vec_t;

  localparam logic [5:0] DC = 6'h3f;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic ctl_t exp_ctl(input int st, input logic rdy);
    ctl_t c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.iord = 1; c.mem_read = 1; end
      4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
      5:  begin c.iord = 1; c.mem_write = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_dst = 1; c.reg_write = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1; end
      9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      10: c.reg_write = 1;
      11: begin c.pc_src = 2'b10; c.pc_write = 1; end
      12: c.halted = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c.pc_write   = bus.pc_write;
    c.branch     = bus.branch;
    c.iord       = bus.iord;
    c.mem_read   = bus.mem_read;
    c.mem_write  = bus.mem_write;
    c.ir_write   = bus.ir_write;
    c.reg_dst    = bus.reg_dst;
    c.mem_to_reg = bus.mem_to_reg;
    c.reg_write  = bus.reg_write;
    c.alu_src_a  = bus.alu_src_a;
    c.alu_src_b  = bus.alu_src_b;
    c.alu_op     = bus.alu_op;
    c.pc_src     = bus.pc_src;
    c.halted     = bus.halted;
    return c;
  endfunction

  function automatic logic [5:0] write_enables();
    return {bus.pc_write, bus.branch, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write};
  endfunction

  task automatic add(input logic [5:0] o, input logic r, input int s, input logic d, input int c);
    vec_t v;
    v.opc = o; v.rdy = r; v.st = s; v.done = d; v.cnt = c;
    vecs.push_back(v);
  endtask

  // Drive inputs now, then move to mid-cycle for sampling.
  task automatic cyc(input logic [5:0] o, input logic r);
    bus.opcode    = o;
    bus.mem_ready = r;
    #4;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    exp_q.push_back(v);
    cyc(v.opc, v.rdy);
    e = exp_q.pop_front();
    chk("vec_state", 32'(bus.state_o), 32'(e.st));
    chk("vec_ctrl", 32'(dut_ctl()), 32'(exp_ctl(e.st, e.rdy)));
    chk("vec_done", 32'(bus.instr_done), 32'(e.done));
    chk("vec_cnt", bus.instr_cnt, 32'(e.cnt));
    chk("vec_bus_err", 32'(bus.bus_err), 32'd0);
    $display("vec %0d: opc=%02h rdy=%0d state=%0d done=%0d cnt=%0d",
             idx, v.opc, v.rdy, bus.state_o, bus.instr_done, bus.instr_cnt);
    adv();
  endtask

  initial begin
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;

    for (int k = 0; k < 3; k++) begin
      add(DC, 1, 0, 0, k); add(6'h00, 1, 1, 0, k); add(DC, 1, 6, 0, k); add(DC, 1, 7, 1, k);
    end
    add(DC, 1, 0, 0, 3); add(6'h23, 1, 1, 0, 3); add(DC, 1, 2, 0, 3);
    add(DC, 0, 3, 0, 3); add(DC, 0, 3, 0, 3); add(DC, 1, 3, 0, 3); add(DC, 1, 4, 1, 3);
    add(DC, 1, 0, 0, 4); add(6'h2b, 0, 1, 0, 4); add(DC, 0, 2, 0, 4); add(DC, 1, 5, 1, 4);
    add(DC, 1, 0, 0, 5); add(6'h04, 1, 1, 0, 5); add(DC, 0, 8, 1, 5);
    add(DC, 1, 0, 0, 6); add(6'h02, 1, 1, 0, 6); add(DC, 1, 11, 1, 6);
    add(DC, 1, 0, 0, 7); add(6'h08, 1, 1, 0, 7); add(DC, 1, 9, 0, 7); add(DC, 0, 10, 1, 7);
    add(DC, 0, 0, 0, 8); add(DC, 1, 0, 0, 8); add(6'h2b, 1, 1, 0, 8); add(DC, 1, 2, 0, 8);
    add(DC, 0, 5, 0, 8); add(DC, 1, 5, 1, 8);
    add(DC, 1, 0, 0, 9); add(6'h3f, 1, 1, 0, 9); add(DC, 1, 12, 0, 9); add(DC, 0, 12, 0, 9);

    // Reset state, sampled mid-cycle while rst_n is still low.
    #12;
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_ctrl", 32'(dut_ctl()), 32'(exp_ctl(0, 1'b0)));
    chk("rst_cnt", bus.instr_cnt, 32'd0);
    chk("rst_done", 32'(bus.instr_done), 32'd0);
    chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
    adv();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // ERR must hold with every write enable low regardless of mem_ready.
    for (int i = 0; i < 20; i++) begin
      cyc(DC, 1'($urandom_range(0, 1)));
      chk("err_state", 32'(bus.state_o), 32'd12);
      chk("err_we", 32'(write_enables()), 32'd0);
      chk("err_halted", 32'(bus.halted), 32'd1);
      adv();
    end
    $display("err hold: 20 cycles in ERR, cnt=%0d", bus.instr_cnt);
    rst_n = 1'b0;
    #1;
    chk("err_rst_state", 32'(bus.state_o), 32'd0);
    chk("err_rst_halted", 32'(bus.halted), 32'd0);
    chk("err_rst_cnt", bus.instr_cnt, 32'd0);
    rst_n = 1'b1;

    // Watchdog: mem_ready low for 15 cycles in FETCH -> bus_err on the 15th.
    for (int i = 1; i <= 15; i++) begin
      cyc(DC, 1'b0);
      chk("wd_bus_err", 32'(bus.bus_err), 32'(i == 15));
      chk("wd_state", 32'(bus.state_o), 32'd0);
      adv();
    end
    chk("wd_err_state", 32'(bus.state_o), 32'd12);
    chk("wd_halted", 32'(bus.halted), 32'd1);
    $display("watchdog timeout: state=%0d", bus.state_o);
    rst_n = 1'b0;
    #1;
    chk("wd_rst_state", 32'(bus.state_o), 32'd0);
    rst_n = 1'b1;

    // Same stall, but the access completes on the 15th cycle.
    for (int i = 1; i <= 15; i++) begin
      cyc(DC, 1'(i == 15));
      chk("wd_edge_bus_err", 32'(bus.bus_err), 32'd0);
      if (i == 15) chk("wd_edge_ir_write", 32'(bus.ir_write), 32'd1);
      adv();
    end
    chk("wd_edge_state", 32'(bus.state_o), 32'd1);
    $display("watchdog edge: state=%0d", bus.state_o);

    // Retire one R-type, then reset asynchronously in the middle of a store.
    cyc(6'h00, 1'b1); adv();
    cyc(DC, 1'b1);    adv();
    cyc(DC, 1'b1);
    chk("seq_alu_done", 32'(bus.instr_done), 32'd1);
    adv();
    chk("seq_cnt1", bus.instr_cnt, 32'd1);
    cyc(DC, 1'b1);    adv();
    cyc(6'h2b, 1'b1); adv();
    cyc(DC, 1'b1);    adv();
    bus.mem_ready = 1'b0;
    #1;
    chk("memwr_state", 32'(bus.state_o), 32'd5);
    chk("memwr_write", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("arst_state", 32'(bus.state_o), 32'd0);
    chk("arst_cnt", bus.instr_cnt, 32'd0);
    chk("arst_done", 32'(bus.instr_done), 32'd0);
    rst_n = 1'b1;
    $display("async reset mid-MEMWR: state=%0d cnt=%0d", bus.state_o, bus.instr_cnt);
    cyc(DC, 1'b1);
    chk("recover_ir_write", 32'(bus.ir_write), 32'd1);
    adv();
    chk("recover_state", 32'(bus.state_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle main control FSM that sequences the shared datapath: register file, ALU, instruction/data memory and PC.
Executes R-type, LW, SW, BEQ, ADDI and J over 3-5 cycles per instruction.
Waits on a memory ready handshake, guards that wait with a watchdog, and counts retired instructions.
Sits beside the decode stage; its outputs drive the datapath muxes and write enables directly.

Parameters:
MAX_WAIT, 15, max consecutive mem_ready=0 cycles tolerated in a memory state before bus error; legal range 1..255.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from IR; sampled in DECODE only
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  PC unconditional load
branch  out  1  PC load if ALU zero (BEQ)
iord  out  1  0 = memory address from PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = MDR, 0 = ALUOut
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  out  1  1-cycle pulse on retire
instr_cnt  out  CNT_W  retired count; wraps modulo 2^CNT_W
bus_err  out  1  1-cycle pulse on watchdog timeout
halted  out  1  high while in ERR
state_o  out  4  current state encoding, for debug

Behaviour:
- All controls are Moore decodes of state, except the FETCH ir_write/pc_write gating below. Any control not listed for a state is 0.
- Reset (async, rst_n=0): state = FETCH, wait_cnt = 0, instr_cnt = 0, bus_err = 0, instr_done = 0.
  - Outputs during reset are therefore the FETCH decode: mem_read=1, alu_src_b=01, everything else 0.
  - Reset mid-instruction abandons the instruction; no write is asserted afterwards.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ERR=12.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write equal mem_ready.
  - Advance to DECODE when mem_ready=1; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other -> ERR
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEMRD for LW, MEMWR for SW, using the opcode registered in DECODE.
- MEMRD: iord=1, mem_read=1. Advance to MEMWB on mem_ready.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Retire; next FETCH.
- MEMWR: iord=1, mem_write=1. Advance on mem_ready and retire in that cycle; next FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
- ALUWB: reg_dst=1, reg_write=1. Retire; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Retire; next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
- ADDIWB: reg_dst=0, reg_write=1. Retire; next FETCH.
- JUMP: pc_src=10, pc_write=1. Retire; next FETCH.
- ERR: all controls 0, halted=1. Exit only via reset.
- Retire cycle: instr_done=1 and instr_cnt increments by 1 in the same cycle (combinational pulse, registered count). Wrap from all-ones to 0 is silent.
- Watchdog:
  - wait_cnt counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - It clears on any state change and whenever mem_ready=1.
  - If mem_ready=0 while wait_cnt==MAX_WAIT-1: bus_err=1 that cycle and next state is ERR.
  - mem_ready=1 in that same cycle takes priority: normal advance, no error.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum/localparams
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUOp, ALUSrcB and PCSrc encodings, reused by the ALU control decoder
- One natural sub-module: ctrl_watchdog (wait counter plus timeout compare, parameter MAX_WAIT).
- FSM and output decode remain in multicycle_ctrl.

Test Plan:
- Reset with mem_ready=1, then R-type opcode -> states 0,1,6,7 repeating; instr_done every 4th cycle; instr_cnt=3 after 12 cycles.
- LW with 2 mem_ready=0 cycles in MEMRD -> MEMRD held 3 cycles; reg_write=1, mem_to_reg=1 only in MEMWB; retire at cycle 7.
- SW then BEQ then J -> SW retires in MEMWR (4 cycles); BEQ asserts branch=1, pc_src=01; J asserts pc_write=1, pc_src=10; instr_cnt=3.
- Opcode 111111 in DECODE -> ERR next cycle; halted=1; all write enables 0 for 20 cycles; rst_n pulse returns state_o=0.
- mem_ready held 0 in FETCH with MAX_WAIT=15 -> bus_err pulses exactly on the 15th wait cycle; ERR next. Repeat with mem_ready=1 on the 15th cycle -> no error, DECODE.
- Assert rst_n=0 asynchronously mid-MEMWR -> mem_write drops immediately; state_o=0 and instr_cnt=0 with no clock edge.
